// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: state encoding and default parameter values shared by the PC controller files.
package pc_unit_pkg;
    typedef enum logic [1:0] {
        STATE_PCU_IDLE   = 2'd0,
        STATE_PCU_RUN    = 2'd1,
        STATE_PCU_HALTED = 2'd2
    } pcu_state_t;
    localparam int DEF_PC_SIZE      = 32;
    localparam int DEF_RESET_VECTOR = 0;
    localparam int DEF_PC_STEP      = 4;
    localparam int DEF_CNT_SIZE     = 32;
endpackage

// File: rtl/pc_fetch_counter.sv
// pc_fetch_counter: saturating up-counter with synchronous clear.
module pc_fetch_counter
    import pc_unit_pkg::*;
#(
    parameter int CNT_SIZE = DEF_CNT_SIZE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_inc,
    output logic [CNT_SIZE-1:0] o_count
);
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_count <= '0;
        else if (i_clear)
            o_count <= '0;
        else if (i_inc && o_count != '1)
            o_count <= o_count + CNT_SIZE'(1);
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: IF-stage program counter with stall, redirect, halt/restart, flush and single-step control.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int PC_SIZE      = DEF_PC_SIZE,
    parameter int RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int PC_STEP      = DEF_PC_STEP,
    parameter int CNT_SIZE     = DEF_CNT_SIZE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_run_mode,
    input  logic                i_step,
    input  logic                i_stall,
    input  logic                i_redirect,
    input  logic [PC_SIZE-1:0]  i_redirect_pc,
    input  logic                i_halt,
    input  logic                i_restart,
    input  logic                i_flush,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic [PC_SIZE-1:0]  o_pc_next_seq,
    output logic                o_valid,
    output logic                o_halted,
    output logic                o_misaligned,
    output logic [1:0]          o_state,
    output logic [CNT_SIZE-1:0] o_fetch_count
);
    localparam logic [PC_SIZE-1:0] RV   = PC_SIZE'(RESET_VECTOR);
    localparam logic [PC_SIZE-1:0] MASK = PC_SIZE'(PC_STEP - 1);

    pcu_state_t state;
    logic       adv, run, tgt_bad, inc;

    assign adv           = i_run_mode | i_step;
    assign run           = state == STATE_PCU_RUN;
    assign tgt_bad       = |(i_redirect_pc & MASK);
    assign o_pc_next_seq = o_pc + PC_SIZE'(PC_STEP);
    assign o_valid       = run & adv & ~i_stall;
    assign o_halted      = state == STATE_PCU_HALTED;
    assign o_state       = state;
    // An accepted update is an aligned redirect or an unstalled advance; halt takes precedence.
    assign inc = i_enable & run & ~i_flush & adv & ~i_halt & (i_redirect ? ~tgt_bad : ~i_stall);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= STATE_PCU_IDLE;
            o_pc         <= RV;
            o_misaligned <= 1'b0;
        end else if (i_enable) begin
            if (i_flush) begin
                state        <= STATE_PCU_IDLE;
                o_pc         <= RV;
                o_misaligned <= 1'b0;
            end else begin
                case (state)
                    STATE_PCU_IDLE: state <= STATE_PCU_RUN;
                    STATE_PCU_RUN: begin
                        if (i_halt && adv)
                            state <= STATE_PCU_HALTED;
                        else if (i_redirect && adv) begin
                            if (tgt_bad) begin
                                o_misaligned <= 1'b1;
                                state        <= STATE_PCU_HALTED;
                            end else
                                o_pc <= i_redirect_pc;
                        end else if (adv && !i_stall)
                            o_pc <= o_pc_next_seq;
                    end
                    STATE_PCU_HALTED: begin
                        if (i_restart) begin
                            state <= STATE_PCU_IDLE;
                            o_pc  <= RV;
                        end
                    end
                    default: state <= STATE_PCU_IDLE;
                endcase
            end
        end
    end

    pc_fetch_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (i_enable & i_flush),
        .i_inc   (inc),
        .o_count (o_fetch_count)
    );
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenario tests for pc_unit at default and narrow (PC_SIZE=8, CNT_SIZE=2) widths.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        reset, enable, run_mode, stp, stall, redir, halt, restart, flush;
    logic [31:0] redir_pc;
    logic [31:0] pc, pc_nxt, cnt;
    logic        valid, halted, mis;
    logic [1:0]  st;
    logic        s_reset, s_redir;
    logic [7:0]  s_redir_pc, pc2, pc2_nxt;
    logic        valid2, halted2, mis2;
    logic [1:0]  st2, cnt2;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pc_unit dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_run_mode(run_mode), .i_step(stp),
        .i_stall(stall), .i_redirect(redir), .i_redirect_pc(redir_pc), .i_halt(halt),
        .i_restart(restart), .i_flush(flush), .o_pc(pc), .o_pc_next_seq(pc_nxt), .o_valid(valid),
        .o_halted(halted), .o_misaligned(mis), .o_state(st), .o_fetch_count(cnt)
    );

    pc_unit #(.PC_SIZE(8), .CNT_SIZE(2)) dut2 (
        .i_clk(clk), .i_reset(s_reset), .i_enable(1'b1), .i_run_mode(1'b1), .i_step(1'b0),
        .i_stall(1'b0), .i_redirect(s_redir), .i_redirect_pc(s_redir_pc), .i_halt(1'b0),
        .i_restart(1'b0), .i_flush(1'b0), .o_pc(pc2), .o_pc_next_seq(pc2_nxt), .o_valid(valid2),
        .o_halted(halted2), .o_misaligned(mis2), .o_state(st2), .o_fetch_count(cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {reset, enable, run_mode, stp, stall, redir, halt, restart, flush} = 9'b1_1_1_000000;
        redir_pc = '0;
        s_reset = 1'b1; s_redir = 1'b0; s_redir_pc = '0;
        tick();
        n_cmp++;
        if ({pc, st, cnt, valid, halted, mis} !== {32'h0, 2'd0, 32'd0, 3'b000}) begin
            n_bad++;
            $display("FAIL reset pc=%h st=%0d cnt=%0d v/h/m=%b%b%b exp 0/0/0/000", pc, st, cnt, valid, halted, mis);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({pc, st, valid} !== {32'h0, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL idle_cycle pc=%h st=%0d valid=%b exp 0/0/0", pc, st, valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({pc, st, cnt, valid} !== {32'(4 * i), 2'd1, 32'(i), 1'b1}) begin
                n_bad++;
                $display("FAIL seq[%0d] pc=%h st=%0d cnt=%0d valid=%b exp %h/1/%0d/1", i, pc, st, cnt, valid, 4 * i, i);
            end
            if (i < 3) tick();
        end
        n_cmp++;
        if (pc_nxt !== 32'h10) begin
            n_bad++;
            $display("FAIL next_seq got %h exp 10", pc_nxt);
        end
    endtask

    task automatic test_stall_redirect();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_cmp++;
        if ({pc, st, cnt} !== {32'h0, 2'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL flush_run pc=%h st=%0d cnt=%0d exp 0/0/0", pc, st, cnt);
        end
        repeat (3) tick();
        stall = 1'b1;
        #1;
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_valid got %b exp 0", valid);
        end
        repeat (2) tick();
        n_cmp++;
        if ({pc, cnt} !== {32'h8, 32'd2}) begin
            n_bad++;
            $display("FAIL stall_hold pc=%h cnt=%0d exp 8/2", pc, cnt);
        end
        redir = 1'b1; redir_pc = 32'h40;
        tick();
        redir = 1'b0; stall = 1'b0;
        n_cmp++;
        if ({pc, cnt} !== {32'h40, 32'd3}) begin
            n_bad++;
            $display("FAIL redirect_over_stall pc=%h cnt=%0d exp 40/3", pc, cnt);
        end
    endtask

    task automatic test_single_step();
        run_mode = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stp = 1'b1;
            #1;
            n_cmp++;
            if (valid !== 1'b1) begin
                n_bad++;
                $display("FAIL step_valid[%0d] got %b exp 1", k, valid);
            end
            tick();
            stp = 1'b0;
            #1;
            n_cmp++;
            if ({pc, valid} !== {32'(32'h44 + 4 * k), 1'b0}) begin
                n_bad++;
                $display("FAIL step_adv[%0d] pc=%h valid=%b exp %h/0", k, pc, valid, 32'h44 + 4 * k);
            end
            repeat (2) tick();
            n_cmp++;
            if (pc !== 32'(32'h44 + 4 * k)) begin
                n_bad++;
                $display("FAIL step_hold[%0d] pc=%h exp %h", k, pc, 32'h44 + 4 * k);
            end
        end
        run_mode = 1'b1;
    endtask

    task automatic test_halt_restart();
        redir = 1'b1; redir_pc = 32'h10;
        tick();
        redir = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        n_cmp++;
        if ({pc, st, halted, cnt} !== {32'h10, 2'd2, 1'b1, 32'd7}) begin
            n_bad++;
            $display("FAIL halt pc=%h st=%0d halted=%b cnt=%0d exp 10/2/1/7", pc, st, halted, cnt);
        end
        redir = 1'b1; redir_pc = 32'h80; stall = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if ({pc, st, valid} !== {32'h10, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL halt_ignore pc=%h st=%0d valid=%b exp 10/2/0", pc, st, valid);
        end
        redir = 1'b0; stall = 1'b0; restart = 1'b1;
        tick();
        restart = 1'b0;
        n_cmp++;
        if ({pc, st, halted, cnt} !== {32'h0, 2'd0, 1'b0, 32'd7}) begin
            n_bad++;
            $display("FAIL restart pc=%h st=%0d halted=%b cnt=%0d exp 0/0/0/7", pc, st, halted, cnt);
        end
        tick();
        n_cmp++;
        if ({pc, st} !== {32'h0, 2'd1}) begin
            n_bad++;
            $display("FAIL restart_run pc=%h st=%0d exp 0/1", pc, st);
        end
    endtask

    task automatic test_misaligned();
        redir = 1'b1; redir_pc = 32'h42;
        tick();
        redir = 1'b0;
        n_cmp++;
        if ({pc, st, mis, cnt} !== {32'h0, 2'd2, 1'b1, 32'd7}) begin
            n_bad++;
            $display("FAIL misaligned pc=%h st=%0d mis=%b cnt=%0d exp 0/2/1/7", pc, st, mis, cnt);
        end
        flush = 1'b1; restart = 1'b1;
        tick();
        flush = 1'b0; restart = 1'b0;
        n_cmp++;
        if ({pc, st, mis, cnt} !== {32'h0, 2'd0, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL flush_halted pc=%h st=%0d mis=%b cnt=%0d exp 0/0/0/0", pc, st, mis, cnt);
        end
    endtask

    task automatic test_enable_and_async_reset();
        tick();
        enable = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({pc, st, cnt} !== {32'h0, 2'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL enable_freeze pc=%h st=%0d cnt=%0d exp 0/1/0", pc, st, cnt);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if ({pc, cnt} !== {32'h4, 32'd1}) begin
            n_bad++;
            $display("FAIL enable_resume pc=%h cnt=%0d exp 4/1", pc, cnt);
        end
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({pc, st, cnt} !== {32'h0, 2'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL async_reset pc=%h st=%0d cnt=%0d exp 0/0/0", pc, st, cnt);
        end
    endtask

    task automatic test_wrap_saturate();
        tick();
        s_reset = 1'b0;
        tick();
        s_redir = 1'b1; s_redir_pc = 8'hFC;
        tick();
        s_redir = 1'b0;
        n_cmp++;
        if ({pc2, pc2_nxt, cnt2} !== {8'hFC, 8'h00, 2'd1}) begin
            n_bad++;
            $display("FAIL wrap_setup pc=%h nxt=%h cnt=%0d exp fc/00/1", pc2, pc2_nxt, cnt2);
        end
        tick();
        n_cmp++;
        if ({pc2, cnt2} !== {8'h00, 2'd2}) begin
            n_bad++;
            $display("FAIL wrap pc=%h cnt=%0d exp 00/2", pc2, cnt2);
        end
        repeat (2) tick();
        n_cmp++;
        if ({pc2, cnt2} !== {8'h08, 2'd3}) begin
            n_bad++;
            $display("FAIL saturate pc=%h cnt=%0d exp 08/3", pc2, cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_single_step();
        test_halt_restart();
        test_misaligned();
        test_enable_and_async_reset();
        test_wrap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised program-counter controller for the IF stage of the MIPS pipeline. Holds the fetch PC and advances it by a fixed step. Applies hazard stalls, branch/jump redirects, halt and restart, and a debug single-step mode. Exports fetch-valid, halt status and a saturating fetch counter to the debug unit.

Parameters:
PC_SIZE, 32, width of PC and redirect target.
RESET_VECTOR, 0, PC value after reset, flush or restart; must be a multiple of PC_STEP.
PC_STEP, 4, sequential increment; power of two, at least 1.
CNT_SIZE, 32, width of fetch counter.

Ports:
i_clk  in  1  clock; all state updates on rising edge.
i_reset  in  1  reset, asynchronous, active-high.
i_enable  in  1  debug clock-enable; 0 freezes all state.
i_run_mode  in  1  1 = continuous run, 0 = single-step.
i_step  in  1  single-step pulse, sampled only when i_run_mode=0.
i_stall  in  1  hazard stall from the hazard unit.
i_redirect  in  1  taken branch/jump this cycle.
i_redirect_pc  in  PC_SIZE  redirect target.
i_halt  in  1  halt instruction decoded.
i_restart  in  1  leave HALTED.
i_flush  in  1  synchronous clear from the debug unit.
o_pc  out  PC_SIZE  current fetch PC.
o_pc_next_seq  out  PC_SIZE  o_pc + PC_STEP, combinational.
o_valid  out  1  fetch at o_pc is valid this cycle.
o_halted  out  1  state == HALTED.
o_misaligned  out  1  sticky; a misaligned redirect was rejected.
o_state  out  2  encoded FSM state.
o_fetch_count  out  CNT_SIZE  number of accepted PC updates.

Behaviour:
- Reset values, asynchronous: state=IDLE, o_pc=RESET_VECTOR, o_valid=0, o_halted=0, o_misaligned=0, o_fetch_count=0.
- States: IDLE=0, RUN=1, HALTED=2; code 3 is unreachable and recovers to IDLE.
- i_enable=0: nothing changes, including the counter. All rules below assume i_enable=1.
- adv = i_run_mode | i_step. The "step" is the qualifying condition; i_step held high acts as continuous run.
- IDLE: o_valid=0, PC held. Next cycle the state goes to RUN. Exactly one idle cycle after reset, flush or restart.
- RUN: o_valid = adv & ~i_stall. Evaluation order, highest priority first:
  1. i_flush: PC=RESET_VECTOR, state=IDLE, counter=0, o_misaligned cleared.
  2. i_halt & adv: state=HALTED, PC held, no count.
  3. i_redirect & adv, target low log2(PC_STEP) bits nonzero: o_misaligned=1, state=HALTED, PC held.
  4. i_redirect & adv, aligned target: PC=i_redirect_pc, count+1. Redirect wins over i_stall.
  5. i_stall: PC held, no count.
  6. adv: PC=PC+PC_STEP, count+1.
  7. otherwise (step mode, no pulse): hold.
- HALTED: o_valid=0, o_halted=1, PC frozen. i_halt, i_redirect and i_stall are ignored.
  - i_restart: state=IDLE, PC=RESET_VECTOR, counter kept, o_misaligned kept.
  - i_flush: same as in RUN; priority over i_restart.
- IDLE with i_flush: stays IDLE for one more cycle.
- Arithmetic: PC+PC_STEP wraps modulo 2^PC_SIZE with no flag. The counter saturates at all-ones.
- Latency: a redirect presented in cycle N appears on o_pc at cycle N+1.
- Reset mid-operation wins immediately, from any state, regardless of i_enable.

Decomposition:
- Shared header pc_unit.vh holds:
  - state encodings STATE_PCU_IDLE, STATE_PCU_RUN, STATE_PCU_HALTED;
  - the default parameter values;
  - the clear macro.
- Natural sub-module: pc_fetch_counter, a saturating up-counter with clear and increment inputs.
- The FSM and PC register stay together in pc_unit.

Test Plan:
1. Reset release, run_mode=1, no hazards → o_pc 0 (valid=0) for one cycle, then 0,4,8,12 with valid=1; fetch_count reaches 3 after the third advance.
2. At pc=8, i_stall high for 2 cycles, then i_redirect=1 with target 0x40 while stalled → pc holds 8 for the stall, then 0x40 next cycle; count increments once.
3. run_mode=0 with an i_step pulse every 3rd cycle → pc advances by 4 only on the cycle after each pulse; o_valid high only in pulse cycles.
4. i_halt at pc=0x10 → o_halted=1, pc stays 0x10 under redirect/stall activity; i_restart → IDLE one cycle, pc=0, counter unchanged.
5. Redirect target 0x42 with PC_STEP=4 → o_misaligned=1, HALTED, pc unchanged; i_flush → misaligned=0, counter=0, pc=0.
6. PC_SIZE=8 at pc=0xFC advancing → pc=0x00 (wrap). CNT_SIZE=2 → counter holds at 3. i_reset asserted mid-RUN between clock edges → outputs reset without waiting for a clock edge.
